// File: rtl/nasti_demux_pkg.sv
// Shared types and constants for the NASTI address demultiplexer.
// Holds the target index type (lanes 0..7, value 8 = internal error sink),
// the AXI response codes and the write/read FSM state encodings.
package nasti_demux_pkg;

   localparam int N_LANES = 8;

   typedef logic [3:0] tgt_t;
   localparam tgt_t TGT_ERR = 4'd8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [0:0] {
      W_IDLE,
      W_DATA
   } wstate_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_FWD,
      R_ERR
   } rstate_t;

endpackage

// File: rtl/nasti_channel.sv
// NASTI channel bundle carrying N_PORT parallel lanes of AW/W/B/AR/R.
// Every field is an unpacked array indexed by lane number.
//   master modport : drives AW/W/AR payload+valid, B/R ready
//   slave modport  : drives AW/W/AR ready, B/R payload+valid
interface nasti_channel #(
   parameter int N_PORT     = 8,
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 1
) ();

   logic [ID_WIDTH-1:0]     aw_id     [N_PORT];
   logic [ADDR_WIDTH-1:0]   aw_addr   [N_PORT];
   logic [7:0]              aw_len    [N_PORT];
   logic [2:0]              aw_size   [N_PORT];
   logic [1:0]              aw_burst  [N_PORT];
   logic                    aw_lock   [N_PORT];
   logic [3:0]              aw_cache  [N_PORT];
   logic [2:0]              aw_prot   [N_PORT];
   logic [3:0]              aw_qos    [N_PORT];
   logic [3:0]              aw_region [N_PORT];
   logic [USER_WIDTH-1:0]   aw_user   [N_PORT];
   logic                    aw_valid  [N_PORT];
   logic                    aw_ready  [N_PORT];

   logic [DATA_WIDTH-1:0]   w_data    [N_PORT];
   logic [DATA_WIDTH/8-1:0] w_strb    [N_PORT];
   logic                    w_last    [N_PORT];
   logic [USER_WIDTH-1:0]   w_user    [N_PORT];
   logic                    w_valid   [N_PORT];
   logic                    w_ready   [N_PORT];

   logic [ID_WIDTH-1:0]     b_id      [N_PORT];
   logic [1:0]              b_resp    [N_PORT];
   logic [USER_WIDTH-1:0]   b_user    [N_PORT];
   logic                    b_valid   [N_PORT];
   logic                    b_ready   [N_PORT];

   logic [ID_WIDTH-1:0]     ar_id     [N_PORT];
   logic [ADDR_WIDTH-1:0]   ar_addr   [N_PORT];
   logic [7:0]              ar_len    [N_PORT];
   logic [2:0]              ar_size   [N_PORT];
   logic [1:0]              ar_burst  [N_PORT];
   logic                    ar_lock   [N_PORT];
   logic [3:0]              ar_cache  [N_PORT];
   logic [2:0]              ar_prot   [N_PORT];
   logic [3:0]              ar_qos    [N_PORT];
   logic [3:0]              ar_region [N_PORT];
   logic [USER_WIDTH-1:0]   ar_user   [N_PORT];
   logic                    ar_valid  [N_PORT];
   logic                    ar_ready  [N_PORT];

   logic [ID_WIDTH-1:0]     r_id      [N_PORT];
   logic [DATA_WIDTH-1:0]   r_data    [N_PORT];
   logic [1:0]              r_resp    [N_PORT];
   logic                    r_last    [N_PORT];
   logic [USER_WIDTH-1:0]   r_user    [N_PORT];
   logic                    r_valid   [N_PORT];
   logic                    r_ready   [N_PORT];

   modport master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
             aw_prot, aw_qos, aw_region, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
             ar_prot, ar_qos, ar_region, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
             aw_prot, aw_qos, aw_region, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
             ar_prot, ar_qos, ar_region, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );

endinterface

// File: rtl/nasti_err_slave.sv
// Sequential DECERR responder for transactions that decode to no lane.
// Inputs : handshake strobes for AW/W-last/B/AR/R of the error target,
//          plus the AW id, AR id and AR burst length.
// Outputs: one pending B beat (b_valid/b_id) and an R beat stream
//          (r_valid/r_id/r_last) of ar_len+1 beats.
module nasti_err_slave #(
   parameter int ID_WIDTH = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                aw_hs,
   input  logic [ID_WIDTH-1:0] aw_id,
   input  logic                w_last_hs,
   input  logic                b_hs,
   input  logic                ar_hs,
   input  logic [ID_WIDTH-1:0] ar_id,
   input  logic [7:0]          ar_len,
   input  logic                r_hs,
   output logic                b_valid,
   output logic [ID_WIDTH-1:0] b_id,
   output logic                r_valid,
   output logic [ID_WIDTH-1:0] r_id,
   output logic                r_last
);
   import nasti_demux_pkg::*;

   logic                b_valid_q, b_valid_d;
   logic [ID_WIDTH-1:0] aw_id_q, aw_id_d;
   logic                r_valid_q, r_valid_d;
   logic [ID_WIDTH-1:0] ar_id_q, ar_id_d;
   logic [7:0]          beat_q, beat_d;

   // The beat counter holds the number of beats still to follow the
   // current one, so the final beat is the one where it reads zero.
   always_comb begin
      b_valid_d = b_valid_q;
      aw_id_d   = aw_id_q;
      r_valid_d = r_valid_q;
      ar_id_d   = ar_id_q;
      beat_d    = beat_q;
      if (aw_hs)
         aw_id_d = aw_id;
      if (b_hs)
         b_valid_d = 1'b0;
      if (w_last_hs)
         b_valid_d = 1'b1;
      if (ar_hs) begin
         r_valid_d = 1'b1;
         beat_d    = ar_len;
         ar_id_d   = ar_id;
      end else if (r_hs) begin
         if (beat_q == 8'd0)
            r_valid_d = 1'b0;
         else
            beat_d = beat_q - 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_valid_q <= 1'b0;
         aw_id_q   <= '0;
         r_valid_q <= 1'b0;
         ar_id_q   <= '0;
         beat_q    <= 8'd0;
      end else begin
         b_valid_q <= b_valid_d;
         aw_id_q   <= aw_id_d;
         r_valid_q <= r_valid_d;
         ar_id_q   <= ar_id_d;
         beat_q    <= beat_d;
      end
   end

   assign b_valid = b_valid_q;
   assign b_id    = aw_id_q;
   assign r_valid = r_valid_q;
   assign r_id    = ar_id_q;
   assign r_last  = (beat_q == 8'd0);

endmodule

// File: rtl/nasti_demux.sv
// Routes one upstream NASTI master (s, lane 0) onto up to 8 downstream
// lanes (m) by address decode and steers B/R responses back upstream.
// Unmapped addresses go to an internal DECERR responder.
//   clk, rst : single clock, asynchronous active-high reset
//   s        : upstream slave-side bundle, lane 0 used
//   m        : downstream master-side bundle, lanes 0..7
// A single-target outstanding window per direction keeps responses in
// order: new requests are accepted only towards the current target, or
// towards any target once the window has drained.
module nasti_demux #(
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 1,
   parameter int W_MAX      = 2,
   parameter int R_MAX      = 2,
   parameter logic [ADDR_WIDTH-1:0] BASE0 = '0, BASE1 = '0, BASE2 = '0, BASE3 = '0,
   parameter logic [ADDR_WIDTH-1:0] BASE4 = '0, BASE5 = '0, BASE6 = '0, BASE7 = '0,
   parameter logic [ADDR_WIDTH-1:0] MASK0 = '0, MASK1 = '0, MASK2 = '0, MASK3 = '0,
   parameter logic [ADDR_WIDTH-1:0] MASK4 = '0, MASK5 = '0, MASK6 = '0, MASK7 = '0
) (
   input  logic         clk,
   input  logic         rst,
   nasti_channel.slave  s,
   nasti_channel.master m
);
   import nasti_demux_pkg::*;

   localparam int WCW = $clog2(W_MAX + 1);
   localparam int RCW = $clog2(R_MAX + 1);
   localparam logic [ADDR_WIDTH-1:0] BASE_A [N_LANES] =
      '{BASE0, BASE1, BASE2, BASE3, BASE4, BASE5, BASE6, BASE7};
   localparam logic [ADDR_WIDTH-1:0] MASK_A [N_LANES] =
      '{MASK0, MASK1, MASK2, MASK3, MASK4, MASK5, MASK6, MASK7};

   // Scanning downwards leaves the lowest matching port as the winner.
   function automatic tgt_t decode(input logic [ADDR_WIDTH-1:0] addr);
      tgt_t t;
      t = TGT_ERR;
      for (int i = N_LANES - 1; i >= 0; i--)
         if (MASK_A[i] != '0 && (addr & MASK_A[i]) == (BASE_A[i] & MASK_A[i]))
            t = tgt_t'(i);
      return t;
   endfunction

   wstate_t        wstate_q, wstate_d;
   rstate_t        rstate_q, rstate_d;
   tgt_t           wtgt_q, wtgt_d, rtgt_q, rtgt_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic [RCW-1:0] rcnt_q, rcnt_d;
   tgt_t           aw_tgt, ar_tgt;
   logic           aw_ok, ar_ok;
   logic           aw_hs, w_hs, b_hs, ar_hs, r_hs, r_last_hs;
   logic                err_b_valid, err_r_valid, err_r_last;
   logic [ID_WIDTH-1:0] err_b_id, err_r_id;

   // Window admission. An error write is held off while its single DECERR
   // B is still pending, and an error read needs an empty read window.
   always_comb begin
      aw_tgt = decode(s.aw_addr[0]);
      ar_tgt = decode(s.ar_addr[0]);
      aw_ok  = !rst && wstate_q == W_IDLE && wcnt_q < WCW'(W_MAX) &&
               (wcnt_q == '0 || aw_tgt == wtgt_q) &&
               !(aw_tgt == TGT_ERR && err_b_valid);
      ar_ok  = !rst && rcnt_q < RCW'(R_MAX) &&
               (rcnt_q == '0 || (ar_tgt == rtgt_q && ar_tgt != TGT_ERR));
   end

   // Lane steering. Payload fields are broadcast to every lane and only
   // the selected lane's valid is raised; everything is gated by reset.
   always_comb begin
      for (int i = 0; i < N_LANES; i++) begin
         m.aw_id[i]     = s.aw_id[0];     m.aw_addr[i]   = s.aw_addr[0];
         m.aw_len[i]    = s.aw_len[0];    m.aw_size[i]   = s.aw_size[0];
         m.aw_burst[i]  = s.aw_burst[0];  m.aw_lock[i]   = s.aw_lock[0];
         m.aw_cache[i]  = s.aw_cache[0];  m.aw_prot[i]   = s.aw_prot[0];
         m.aw_qos[i]    = s.aw_qos[0];    m.aw_region[i] = s.aw_region[0];
         m.aw_user[i]   = s.aw_user[0];   m.aw_valid[i]  = 1'b0;
         m.w_data[i]    = s.w_data[0];    m.w_strb[i]    = s.w_strb[0];
         m.w_last[i]    = s.w_last[0];    m.w_user[i]    = s.w_user[0];
         m.w_valid[i]   = 1'b0;           m.b_ready[i]   = 1'b0;
         m.ar_id[i]     = s.ar_id[0];     m.ar_addr[i]   = s.ar_addr[0];
         m.ar_len[i]    = s.ar_len[0];    m.ar_size[i]   = s.ar_size[0];
         m.ar_burst[i]  = s.ar_burst[0];  m.ar_lock[i]   = s.ar_lock[0];
         m.ar_cache[i]  = s.ar_cache[0];  m.ar_prot[i]   = s.ar_prot[0];
         m.ar_qos[i]    = s.ar_qos[0];    m.ar_region[i] = s.ar_region[0];
         m.ar_user[i]   = s.ar_user[0];   m.ar_valid[i]  = 1'b0;
         m.r_ready[i]   = 1'b0;
         s.aw_ready[i]  = 1'b0;           s.w_ready[i]   = 1'b0;
         s.b_valid[i]   = 1'b0;           s.b_id[i]      = '0;
         s.b_resp[i]    = RESP_OKAY;      s.b_user[i]    = '0;
         s.ar_ready[i]  = 1'b0;           s.r_valid[i]   = 1'b0;
         s.r_id[i]      = '0;             s.r_data[i]    = '0;
         s.r_resp[i]    = RESP_OKAY;      s.r_last[i]    = 1'b0;
         s.r_user[i]    = '0;
      end
      if (aw_ok) begin
         if (aw_tgt == TGT_ERR)
            s.aw_ready[0] = 1'b1;
         else begin
            m.aw_valid[aw_tgt[2:0]] = s.aw_valid[0];
            s.aw_ready[0]           = m.aw_ready[aw_tgt[2:0]];
         end
      end
      if (!rst && wstate_q == W_DATA) begin
         if (wtgt_q == TGT_ERR)
            s.w_ready[0] = 1'b1;
         else begin
            m.w_valid[wtgt_q[2:0]] = s.w_valid[0];
            s.w_ready[0]           = m.w_ready[wtgt_q[2:0]];
         end
      end
      if (!rst && wcnt_q != '0) begin
         if (wtgt_q == TGT_ERR) begin
            s.b_valid[0] = err_b_valid;
            s.b_id[0]    = err_b_id;
            s.b_resp[0]  = RESP_DECERR;
         end else begin
            s.b_valid[0]          = m.b_valid[wtgt_q[2:0]];
            s.b_id[0]             = m.b_id[wtgt_q[2:0]];
            s.b_resp[0]           = m.b_resp[wtgt_q[2:0]];
            s.b_user[0]           = m.b_user[wtgt_q[2:0]];
            m.b_ready[wtgt_q[2:0]] = s.b_ready[0];
         end
      end
      if (ar_ok) begin
         if (ar_tgt == TGT_ERR)
            s.ar_ready[0] = 1'b1;
         else begin
            m.ar_valid[ar_tgt[2:0]] = s.ar_valid[0];
            s.ar_ready[0]           = m.ar_ready[ar_tgt[2:0]];
         end
      end
      if (!rst && rstate_q == R_ERR) begin
         s.r_valid[0] = err_r_valid;
         s.r_id[0]    = err_r_id;
         s.r_resp[0]  = RESP_DECERR;
         s.r_last[0]  = err_r_last;
      end else if (!rst && rstate_q == R_FWD) begin
         s.r_valid[0]           = m.r_valid[rtgt_q[2:0]];
         s.r_id[0]              = m.r_id[rtgt_q[2:0]];
         s.r_data[0]            = m.r_data[rtgt_q[2:0]];
         s.r_resp[0]            = m.r_resp[rtgt_q[2:0]];
         s.r_last[0]            = m.r_last[rtgt_q[2:0]];
         s.r_user[0]            = m.r_user[rtgt_q[2:0]];
         m.r_ready[rtgt_q[2:0]] = s.r_ready[0];
      end
   end

   assign aw_hs     = s.aw_valid[0] && s.aw_ready[0];
   assign w_hs      = s.w_valid[0] && s.w_ready[0];
   assign b_hs      = s.b_valid[0] && s.b_ready[0];
   assign ar_hs     = s.ar_valid[0] && s.ar_ready[0];
   assign r_hs      = s.r_valid[0] && s.r_ready[0];
   assign r_last_hs = r_hs && s.r_last[0];

   // Write FSM, target latch and outstanding-write counter.
   always_comb begin
      wstate_d = wstate_q;
      wtgt_d   = wtgt_q;
      case (wstate_q)
         W_IDLE:  if (aw_hs) begin
                     wtgt_d   = aw_tgt;
                     wstate_d = W_DATA;
                  end
         W_DATA:  if (w_hs && s.w_last[0]) wstate_d = W_IDLE;
         default: wstate_d = W_IDLE;
      endcase
      case ({aw_hs, b_hs})
         2'b10:   wcnt_d = wcnt_q + WCW'(1);
         2'b01:   wcnt_d = wcnt_q - WCW'(1);
         default: wcnt_d = wcnt_q;
      endcase
   end

   // Read FSM: idle with an empty window, otherwise forwarding from a lane
   // or replaying beats from the error responder.
   always_comb begin
      rtgt_d = ar_hs ? ar_tgt : rtgt_q;
      case ({ar_hs, r_last_hs})
         2'b10:   rcnt_d = rcnt_q + RCW'(1);
         2'b01:   rcnt_d = rcnt_q - RCW'(1);
         default: rcnt_d = rcnt_q;
      endcase
      if (rcnt_d == '0)
         rstate_d = R_IDLE;
      else if (rtgt_d == TGT_ERR)
         rstate_d = R_ERR;
      else
         rstate_d = R_FWD;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate_q <= W_IDLE;
         rstate_q <= R_IDLE;
         wtgt_q   <= '0;
         rtgt_q   <= '0;
         wcnt_q   <= '0;
         rcnt_q   <= '0;
      end else begin
         wstate_q <= wstate_d;
         rstate_q <= rstate_d;
         wtgt_q   <= wtgt_d;
         rtgt_q   <= rtgt_d;
         wcnt_q   <= wcnt_d;
         rcnt_q   <= rcnt_d;
      end
   end

   nasti_err_slave #(.ID_WIDTH(ID_WIDTH)) u_err (
      .clk       (clk),
      .rst       (rst),
      .aw_hs     (aw_hs && aw_tgt == TGT_ERR),
      .aw_id     (s.aw_id[0]),
      .w_last_hs (w_hs && s.w_last[0] && wtgt_q == TGT_ERR),
      .b_hs      (b_hs && wtgt_q == TGT_ERR),
      .ar_hs     (ar_hs && ar_tgt == TGT_ERR),
      .ar_id     (s.ar_id[0]),
      .ar_len    (s.ar_len[0]),
      .r_hs      (r_hs && rstate_q == R_ERR),
      .b_valid   (err_b_valid),
      .b_id      (err_b_id),
      .r_valid   (err_r_valid),
      .r_id      (err_r_id),
      .r_last    (err_r_last)
   );

endmodule
